config_tx_fd: RTL
=================

Name: config_tx_fd

Overview:
- Transmit side of the configuration serial link.
- On `start`, snapshots the eight stored 16-bit configuration limits (temp_lim1..7, umidade_lim) and sends them back as eight serial frames.
- Frame format matches receptor_16. Used by the host to read back and confirm the active configuration.
- Sits beside the config manager datapath; its control FSM is internal.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud).
- GAP_BITS, 1, extra idle-high bit times after each stop bit (0..3).

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of `clock`
- start  in  1  request a full readback; level sampled in IDLE only
- temp_lim1 .. temp_lim7  in  16 each  temperature limits; word 0..6
- umidade_lim  in  16  humidity limit; word 7
- tx_serial  out  1  serial line, idle high
- busy  out  1  high from LOAD through the last NEXT, inclusive
- pronto  out  1  one-cycle pulse when the readback completes
- db_estado  out  3  current FSM state encoding
- db_word_idx  out  4  index of the word being sent

Behaviour:
- Reset (reset==0 at an edge) forces, on that edge: state IDLE, tx_serial=1, busy=0, pronto=0, db_word_idx=0, bit/baud counters 0.
- Reset mid-frame abandons the frame immediately. Line is high the cycle after; no resumption.
- Frame, per word: start bit 0; 16 data bits LSB first; even parity bit (total ones over data+parity even); stop bit 1; then GAP_BITS idle-high bit times.
- Each bit is held exactly CLKS_PER_BIT cycles.
- FSM states (encoding on db_estado):
  - IDLE 000: tx=1. If start==1, go to LOAD.
  - LOAD 001: one cycle. Copy all eight inputs into shadow registers; idx=0; busy=1.
  - START 010: tx=0 for one bit time.
  - DATA 011: 16 bit times, shifting shadow[idx] LSB first.
  - PARITY 100: one bit time.
  - STOP 101: tx=1 for (1+GAP_BITS) bit times.
  - NEXT 110: one cycle, tx=1. If idx==7, go to DONE; else idx+1 and go to START.
  - DONE 111: one cycle. pronto=1, busy=0, tx=1. Then IDLE.
- Timing: start sampled at cycle 0 → LOAD at cycle 1 → first start bit at cycle 2.
- Each word occupies (19+GAP_BITS)*CLKS_PER_BIT cycles, plus 1 NEXT cycle.
- Input changes after LOAD do not affect the frames in flight (shadow copy).
- start while busy, or in DONE, is ignored; no queuing. A start held high re-triggers from IDLE on the cycle after DONE.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit counter advances on wrap only.
- db_word_idx shows the shadow index; it is 0 in IDLE.

Optional Feature:
- Macro CONFIG_TX_HEADER_EN.
- When defined: a header word 16'hA5A5 is sent as frame 0, before the eight config words. Uses the same frame format. db_word_idx counts 0..8 (0 = header). NEXT terminates at idx==8.
- When undefined: exactly eight frames, idx 0..7, no header logic compiled.

Decomposition:
- Package config_tx_pkg holds:
  - state encodings (3-bit localparams)
  - DATA_BITS=16, NUM_WORDS=8
  - HEADER_WORD=16'hA5A5
  - even-parity helper function
- Natural sub-module: tx_serial_16, a one-frame serializer with ports start, data[15:0], tx, pronto.
  - Top FSM sequences words and shadows; tx_serial_16 owns the baud/bit counters and the START/DATA/PARITY/STOP timing.
  - db_estado then reflects the combined state.

Test Plan (CLKS_PER_BIT=4, GAP_BITS=1 → 80 cycles per frame):
- Reset low 2 cycles, then high, start=0 → tx_serial=1, busy=0, pronto=0, db_estado=000 indefinitely.
- temp_lim1=16'h0019, pulse start at cycle 0:
  - busy=1 at cycle 1.
  - tx low during cycles 2..5.
  - data bits 1,0,0,1,1,0,... each 4 cycles.
  - parity=1 (three ones).
  - pronto single pulse at cycle 650, busy=0 at the same cycle.
- Change all inputs to 16'hFFFF at cycle 10 after start → all eight frames carry the pre-start values; frame for umidade_lim decodes to its snapshot.
- Pulse start again at cycles 100 and 650 → no restart; exactly one pronto at cycle 650; next readback begins only if start is seen in IDLE.
- Assert reset at cycle 30 (mid-DATA of word 0) → tx_serial=1 and busy=0 from the next cycle. A later start sends word 0 from its start bit.
- With CONFIG_TX_HEADER_EN: first frame is 16'hA5A5 (parity 0); temp_lim1 is frame 1; pronto at cycle 731.

Source files
------------

// File: rtl/config_tx_pkg.sv
// Shared types and helpers for the configuration readback transmitter.
// CONFIG_TX_HEADER_EN adds a 16'hA5A5 header frame ahead of the eight words.
package config_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_LOAD   = 3'b001;
  localparam logic [2:0] ST_START  = 3'b010;
  localparam logic [2:0] ST_DATA   = 3'b011;
  localparam logic [2:0] ST_PARITY = 3'b100;
  localparam logic [2:0] ST_STOP   = 3'b101;
  localparam logic [2:0] ST_NEXT   = 3'b110;
  localparam logic [2:0] ST_DONE   = 3'b111;

  localparam int DATA_BITS = 16;
  localparam int NUM_WORDS = 8;

  localparam logic [15:0] HEADER_WORD = 16'hA5A5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } ser_state_t;

  typedef enum logic [2:0] {
    Q_IDLE = ST_IDLE,
    Q_LOAD = ST_LOAD,
    Q_SEND = ST_START,
    Q_NEXT = ST_NEXT,
    Q_DONE = ST_DONE
  } seq_state_t;

  // Bit that makes the ones count over data+parity even.
  function automatic logic even_parity(
    input logic [DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/tx_serial_16.sv
// One-frame serializer: start, 16 data bits LSB first, even parity, stop+gap.
// Data must stay stable for the whole frame; it is read live, not latched.
module tx_serial_16
  import config_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int GAP_BITS     = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 pronto,
  output logic [2:0]           phase
);

  localparam int BW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS);

  ser_state_t    state, nxt;
  logic [BW-1:0] baud;
  logic [3:0]    bit_cnt;
  logic          tick;

  assign tick  = (baud == BAUD_LAST);
  assign phase = state;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_cnt <= '0;
    end else begin
      state <= nxt;
      if (nxt != state || state == S_IDLE) begin
        baud    <= '0;
        bit_cnt <= '0;
      end else if (tick) begin
        baud    <= '0;
        bit_cnt <= bit_cnt + 4'd1;
      end else begin
        baud <= baud + 1'b1;
      end
    end
  end

  always_comb begin
    nxt    = state;
    pronto = 1'b0;
    tx     = 1'b1;
    case (state)
      S_IDLE: begin
        if (start) nxt = S_START;
      end
      S_START: begin
        tx = 1'b0;
        if (tick) nxt = S_DATA;
      end
      S_DATA: begin
        tx = data[bit_cnt];
        if (tick && bit_cnt == BIT_LAST) nxt = S_PARITY;
      end
      S_PARITY: begin
        tx = even_parity(data);
        if (tick) nxt = S_STOP;
      end
      S_STOP: begin
        if (tick && bit_cnt == GAP_LAST) begin
          nxt    = S_IDLE;
          pronto = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: rtl/config_tx_fd.sv
// Configuration readback: snapshots the limits, sends one frame per word.
// CONFIG_TX_HEADER_EN prepends a 16'hA5A5 header frame (index 0).
module config_tx_fd
  import config_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int GAP_BITS     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] temp_lim1,
  input  logic [15:0] temp_lim2,
  input  logic [15:0] temp_lim3,
  input  logic [15:0] temp_lim4,
  input  logic [15:0] temp_lim5,
  input  logic [15:0] temp_lim6,
  input  logic [15:0] temp_lim7,
  input  logic [15:0] umidade_lim,
  output logic        tx_serial,
  output logic        busy,
  output logic        pronto,
  output logic [2:0]  db_estado,
  output logic [3:0]  db_word_idx
);

`ifdef CONFIG_TX_HEADER_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  localparam int NW = NUM_WORDS + OFF;
  localparam int IW = $clog2(NW);
  localparam logic [3:0] LAST = 4'(NW - 1);

  seq_state_t  state, nxt;
  logic [15:0] cfg [NUM_WORDS];
  logic [15:0] shadow [NW];
  logic [15:0] word;
  logic [3:0]  idx;
  logic        ser_start;
  logic        ser_done;
  logic [2:0]  ser_phase;

  assign cfg[0] = temp_lim1;
  assign cfg[1] = temp_lim2;
  assign cfg[2] = temp_lim3;
  assign cfg[3] = temp_lim4;
  assign cfg[4] = temp_lim5;
  assign cfg[5] = temp_lim6;
  assign cfg[6] = temp_lim7;
  assign cfg[7] = umidade_lim;

  assign word        = shadow[idx[IW-1:0]];
  assign db_word_idx = idx;

  tx_serial_16 #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .GAP_BITS    (GAP_BITS)
  ) u_ser (
    .clock (clock),
    .reset (reset),
    .start (ser_start),
    .data  (word),
    .tx    (tx_serial),
    .pronto(ser_done),
    .phase (ser_phase)
  );

  always_ff @(posedge clock) begin
    if (state == Q_LOAD) begin
      for (int i = 0; i < NUM_WORDS; i++)
        shadow[i+OFF] <= cfg[i];
`ifdef CONFIG_TX_HEADER_EN
      shadow[0] <= HEADER_WORD;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= Q_IDLE;
      idx   <= '0;
    end else begin
      state <= nxt;
      if (state == Q_LOAD || state == Q_DONE)
        idx <= '0;
      else if (state == Q_NEXT && idx != LAST)
        idx <= idx + 4'd1;
    end
  end

  always_comb begin
    nxt       = state;
    ser_start = 1'b0;
    busy      = 1'b0;
    pronto    = 1'b0;
    db_estado = ST_IDLE;
    unique case (state)
      Q_IDLE: begin
        if (start) nxt = Q_LOAD;
      end
      Q_LOAD: begin
        busy      = 1'b1;
        ser_start = 1'b1;
        db_estado = ST_LOAD;
        nxt       = Q_SEND;
      end
      Q_SEND: begin
        busy      = 1'b1;
        db_estado = ser_phase;
        if (ser_done) nxt = Q_NEXT;
      end
      Q_NEXT: begin
        busy      = 1'b1;
        db_estado = ST_NEXT;
        if (idx == LAST) begin
          nxt = Q_DONE;
        end else begin
          ser_start = 1'b1;
          nxt       = Q_SEND;
        end
      end
      Q_DONE: begin
        pronto    = 1'b1;
        db_estado = ST_DONE;
        nxt       = Q_IDLE;
      end
      default: nxt = Q_IDLE;
    endcase
  end

endmodule
